// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : shared constants and helpers for the VGA raster timing engine.
//           Holds the named default display modes and a helper that turns the
//           four per-axis numbers (active, front porch, sync, back porch) into
//           the axis total and the sync window boundaries.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // 640x480 @ 60 Hz
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x480 panel timing
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 480;
  localparam int VGA800_V_FP     = 11;
  localparam int VGA800_V_SYNC   = 2;
  localparam int VGA800_V_BP     = 31;

  // Per-axis boundaries; the sync window is [sync_start, sync_end).
  typedef struct packed {
    int unsigned total;
    int unsigned sync_start;
    int unsigned sync_end;
  } vga_bounds_t;

  function automatic vga_bounds_t vga_bounds(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    vga_bounds_t b;
    b.total      = active + fp + sync + bp;
    b.sync_start = active + fp;
    b.sync_end   = active + fp + sync;
    return b;
  endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// -----------------------------------------------------------------------------
// vga_timing_engine_if
// Purpose : bundles the pixel tick and the registered raster outputs of the
//           timing engine.
// Signals : pixEn (tick into the engine), active, hSync, vSync, x[X_W],
//           y[Y_W], lineStart, screenEnd, frameCount[FC_W].
// Modports: master - the timing engine (consumes pixEn, drives the raster)
//           slave  - the downstream consumer (drives pixEn, reads the raster)
// X_W/Y_W must equal $clog2(H_TOTAL)/$clog2(V_TOTAL) of the engine instance.
// -----------------------------------------------------------------------------
interface vga_timing_engine_if #(
  parameter int X_W  = 10,
  parameter int Y_W  = 10,
  parameter int FC_W = 8
) ();
  logic            pixEn;
  logic            active;
  logic            hSync;
  logic            vSync;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic            lineStart;
  logic            screenEnd;
  logic [FC_W-1:0] frameCount;

  modport master (
    input  pixEn,
    output active, hSync, vSync, x, y, lineStart, screenEnd, frameCount
  );

  modport slave (
    output pixEn,
    input  active, hSync, vSync, x, y, lineStart, screenEnd, frameCount
  );
endinterface

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Purpose : enable-gated register chain of DEPTH stages, WIDTH bits wide.
//           Every stage shifts only when en=1. Asynchronous reset loads every
//           stage with RST_VAL. DEPTH=0 degenerates to a plain wire.
// Ports   : clk, rst (async, active-high), en (shift enable),
//           din[WIDTH] (chain input), dout[WIDTH] (last stage).
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i];
        end
        if (en) begin
          stage_d[0] = din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_engine.sv
// -----------------------------------------------------------------------------
// vga_timing_engine
// Purpose : parametrised VGA raster timing generator. Horizontal/vertical
//           position counters and a frame counter advance on pixEn; the
//           current position is decoded into a raster bundle which is
//           registered (stage 0) and then delayed PIPE_DELAY further pixEn
//           ticks so it lines up with a downstream pixel pipeline.
// Ports   : clk25  - pixel or system clock
//           reset  - asynchronous, active-high
//           vif    - vga_timing_engine_if.master: pixEn in; active, hSync,
//                    vSync, x, y, lineStart, screenEnd, frameCount out.
// -----------------------------------------------------------------------------
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE         = VGA640_H_ACTIVE,
  parameter int H_FP             = VGA640_H_FP,
  parameter int H_SYNC           = VGA640_H_SYNC,
  parameter int H_BP             = VGA640_H_BP,
  parameter int V_ACTIVE         = VGA640_V_ACTIVE,
  parameter int V_FP             = VGA640_V_FP,
  parameter int V_SYNC           = VGA640_V_SYNC,
  parameter int V_BP             = VGA640_V_BP,
  parameter bit HSYNC_ACTIVE_LOW = 1'b1,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int PIPE_DELAY       = 0,
  parameter int FC_W             = 8
) (
  input  logic                 clk25,
  input  logic                 reset,
  vga_timing_engine_if.master  vif
);

  localparam vga_bounds_t HB = vga_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam vga_bounds_t VB = vga_bounds(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_TOTAL = int'(HB.total);
  localparam int V_TOTAL = int'(VB.total);
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);

  // Every boundary is strictly below the axis total (all porches >= 1),
  // so each fits in the coordinate width.
  localparam logic [X_W-1:0] H_LAST       = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_START = X_W'(HB.sync_start);
  localparam logic [X_W-1:0] H_SYNC_END   = X_W'(HB.sync_end);
  localparam logic [Y_W-1:0] V_LAST       = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SYNC_START = Y_W'(VB.sync_start);
  localparam logic [Y_W-1:0] V_SYNC_END   = Y_W'(VB.sync_end);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 15 || FC_W < 1) begin : g_bad_params
      $error("vga_timing_engine: illegal timing parameters");
    end
  endgenerate

  typedef struct packed {
    logic            active;
    logic            h_sync;
    logic            v_sync;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic            line_start;
    logic            screen_end;
    logic [FC_W-1:0] frame_count;
  } bundle_t;

  // Reset image of every pipeline stage: syncs sit at their inactive level.
  localparam bundle_t RST_BUNDLE = '{
    active:      1'b0,
    h_sync:      HSYNC_ACTIVE_LOW,
    v_sync:      VSYNC_ACTIVE_LOW,
    x:           '0,
    y:           '0,
    line_start:  1'b0,
    screen_end:  1'b0,
    frame_count: '0
  };
  localparam int BUNDLE_W = $bits(bundle_t);

  logic [X_W-1:0]  h_pos_q, h_pos_d;
  logic [Y_W-1:0]  v_pos_q, v_pos_d;
  logic [FC_W-1:0] frame_q, frame_d;
  bundle_t         bundle_p0;
  bundle_t         bundle_out;
  logic            h_act, v_act;

  always_comb begin
    h_pos_d = h_pos_q;
    v_pos_d = v_pos_q;
    frame_d = frame_q;
    if (vif.pixEn) begin
      if (h_pos_q == H_LAST) begin
        h_pos_d = '0;
        if (v_pos_q == V_LAST) begin
          v_pos_d = '0;
          frame_d = frame_q + FC_W'(1);
        end else begin
          v_pos_d = v_pos_q + Y_W'(1);
        end
      end else begin
        h_pos_d = h_pos_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      h_pos_q <= '0;
      v_pos_q <= '0;
      frame_q <= '0;
    end else begin
      h_pos_q <= h_pos_d;
      v_pos_q <= v_pos_d;
      frame_q <= frame_d;
    end
  end

  // ---- decode of the current counter state (feeds stage p0) ----
  always_comb begin
    h_act                 = (h_pos_q < H_ACT_END);
    v_act                 = (v_pos_q < V_ACT_END);
    bundle_p0             = RST_BUNDLE;
    bundle_p0.active      = h_act && v_act;
    // Sync is asserted inside its window; XOR applies the output polarity.
    bundle_p0.h_sync      = ((h_pos_q >= H_SYNC_START) && (h_pos_q < H_SYNC_END))
                            ^ HSYNC_ACTIVE_LOW;
    bundle_p0.v_sync      = ((v_pos_q >= V_SYNC_START) && (v_pos_q < V_SYNC_END))
                            ^ VSYNC_ACTIVE_LOW;
    bundle_p0.x           = h_act ? h_pos_q : '0;
    bundle_p0.y           = v_act ? v_pos_q : '0;
    bundle_p0.line_start  = (h_pos_q == '0);
    bundle_p0.screen_end  = (h_pos_q == H_LAST) && (v_pos_q == V_LAST);
    bundle_p0.frame_count = frame_q;
  end

  // ---- stage p0 register plus PIPE_DELAY alignment stages ----
  // The whole bundle travels through one chain so no field can skew.
  vga_delay_line #(
    .WIDTH   (BUNDLE_W),
    .DEPTH   (PIPE_DELAY + 1),
    .RST_VAL (RST_BUNDLE)
  ) u_out_pipe (
    .clk  (clk25),
    .rst  (reset),
    .en   (vif.pixEn),
    .din  (bundle_p0),
    .dout (bundle_out)
  );

  assign vif.active     = bundle_out.active;
  assign vif.hSync      = bundle_out.h_sync;
  assign vif.vSync      = bundle_out.v_sync;
  assign vif.x          = bundle_out.x;
  assign vif.y          = bundle_out.y;
  assign vif.lineStart  = bundle_out.line_start;
  assign vif.screenEnd  = bundle_out.screen_end;
  assign vif.frameCount = bundle_out.frame_count;

endmodule

// File: tb/tb_vga_timing_engine.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_engine
// Two engines in a small 14x7 raster: A (PIPE_DELAY=0, active-low syncs,
// FC_W=2) and B (PIPE_DELAY=3, active-high syncs, FC_W=8) share clock, reset
// and pixEn. A raster model derived from the enabled-edge count predicts
// every output on every cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_vga_timing_engine;
  localparam int HA = 8, HF = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VF = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HF + HS + HBP;   // 14
  localparam int VT = VA + VF + VS + VBP;   // 7
  localparam int XW = 4;                    // $clog2(14)
  localparam int YW = 3;                    // $clog2(7)

  logic clk25 = 1'b0;
  logic reset;
  logic pix_en;
  always #5 clk25 = ~clk25;

  vga_timing_engine_if #(.X_W(XW), .Y_W(YW), .FC_W(2)) ifa ();
  vga_timing_engine_if #(.X_W(XW), .Y_W(YW), .FC_W(8)) ifb ();
  assign ifa.pixEn = pix_en;
  assign ifb.pixEn = pix_en;

  vga_timing_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1),
    .PIPE_DELAY(0), .FC_W(2)
  ) dut_a (.clk25(clk25), .reset(reset), .vif(ifa.master));

  vga_timing_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0),
    .PIPE_DELAY(3), .FC_W(8)
  ) dut_b (.clk25(clk25), .reset(reset), .vif(ifb.master));

  int checks = 0;
  int failures = 0;
  int n;            // enabled edges since the last reset
  bit run_chk = 0;

  always @(posedge clk25 or posedge reset) begin
    if (reset) n <= 0;
    else if (pix_en) n <= n + 1;
  end

  typedef struct {
    int active; int hs; int vs; int x; int y; int ls; int se; int fc;
  } exp_t;

  // Output after cnt enabled edges shows the raster position reached after
  // cnt-1-pd edges; before that the pipeline still holds reset values.
  function automatic exp_t model(int cnt, int pd, int hlow, int vlow, int fcw);
    exp_t e;
    int k, h, v;
    e = '{0, hlow, vlow, 0, 0, 0, 0, 0};
    k = cnt - 1 - pd;
    if (k >= 0) begin
      h = k % HT;
      v = (k / HT) % VT;
      e.active = (h < HA && v < VA) ? 1 : 0;
      e.hs = (h >= HA + HF && h < HA + HF + HS) ? 1 - hlow : hlow;
      e.vs = (v >= VA + VF && v < VA + VF + VS) ? 1 - vlow : vlow;
      e.x  = (h < HA) ? h : 0;
      e.y  = (v < VA) ? v : 0;
      e.ls = (h == 0) ? 1 : 0;
      e.se = (h == HT - 1 && v == VT - 1) ? 1 : 0;
      e.fc = (k / (HT * VT)) % (1 << fcw);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d (n=%0d t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  task automatic cmp8(input string tag, input exp_t e, input int a, input int hs,
                      input int vs, input int x, input int y, input int ls,
                      input int se, input int fc);
    chk({tag, ".active"}, a, e.active);
    chk({tag, ".hSync"}, hs, e.hs);
    chk({tag, ".vSync"}, vs, e.vs);
    chk({tag, ".x"}, x, e.x);
    chk({tag, ".y"}, y, e.y);
    chk({tag, ".lineStart"}, ls, e.ls);
    chk({tag, ".screenEnd"}, se, e.se);
    chk({tag, ".frameCount"}, fc, e.fc);
  endtask

  exp_t ea, eb;
  bit   se_seen_a, se_seen_b;
  int   prev_fc;
  int   fc_val[$];
  int   fc_n[$];

  always @(negedge clk25) begin
    if (run_chk) begin
      ea = model(n, 0, 1, 1, 2);
      eb = model(n, 3, 0, 0, 8);
      cmp8("A", ea, int'(ifa.active), int'(ifa.hSync), int'(ifa.vSync), int'(ifa.x),
           int'(ifa.y), int'(ifa.lineStart), int'(ifa.screenEnd), int'(ifa.frameCount));
      cmp8("B", eb, int'(ifb.active), int'(ifb.hSync), int'(ifb.vSync), int'(ifb.x),
           int'(ifb.y), int'(ifb.lineStart), int'(ifb.screenEnd), int'(ifb.frameCount));

      // Hand-computed anchors for the model.
      if (n == 0) begin
        chk("lit_A_rst_active", int'(ifa.active), 0);
        chk("lit_A_rst_hSync", int'(ifa.hSync), 1);
        chk("lit_A_rst_vSync", int'(ifa.vSync), 1);
        chk("lit_B_rst_hSync", int'(ifb.hSync), 0);
        chk("lit_B_rst_vSync", int'(ifb.vSync), 0);
      end
      if (n == 1) begin
        chk("lit_A_first_active", int'(ifa.active), 1);
        chk("lit_A_first_x", int'(ifa.x), 0);
        chk("lit_A_first_y", int'(ifa.y), 0);
        chk("lit_A_first_lineStart", int'(ifa.lineStart), 1);
        chk("lit_A_first_fc", int'(ifa.frameCount), 0);
      end
      if (n == 3) chk("lit_B_still_reset_active", int'(ifb.active), 0);
      if (n == 4) chk("lit_B_first_lineStart", int'(ifb.lineStart), 1);
      if (n == 8) chk("lit_A_x7", int'(ifa.x), 7);
      if (n == 9) chk("lit_A_x_blank", int'(ifa.x), 0);
      if (n == 10) chk("lit_A_hSync_h9", int'(ifa.hSync), 1);
      if (n == 11) chk("lit_A_hSync_h10", int'(ifa.hSync), 0);
      if (n == 12) chk("lit_A_hSync_h11", int'(ifa.hSync), 0);
      if (n == 13) chk("lit_A_hSync_h12", int'(ifa.hSync), 1);
      if (n == 14) chk("lit_B_hSync_h10", int'(ifb.hSync), 1);
      if (n == 70) chk("lit_A_vSync_v4", int'(ifa.vSync), 1);
      if (n == 71) chk("lit_A_vSync_v5", int'(ifa.vSync), 0);
      if (n == 74) chk("lit_B_vSync_v5", int'(ifb.vSync), 1);
      if (n == 88) chk("lit_B_vSync_v6", int'(ifb.vSync), 0);

      if (n == 0) begin
        se_seen_a = 0;
        se_seen_b = 0;
        prev_fc = 0;
        fc_val.delete();
        fc_n.delete();
      end else begin
        if (ifa.screenEnd && !se_seen_a) begin
          chk("lit_A_first_screenEnd_edge", n, 98);
          se_seen_a = 1;
        end
        if (ifb.screenEnd && !se_seen_b) begin
          chk("lit_B_first_screenEnd_edge", n, 101);
          se_seen_b = 1;
        end
        if (int'(ifa.frameCount) != prev_fc) begin
          prev_fc = int'(ifa.frameCount);
          fc_val.push_back(prev_fc);
          fc_n.push_back(n);
        end
      end
    end
  end

  task automatic run_until(input int target, input int budget, input int mode);
    int guard = 0;
    while (n < target && guard < budget) begin
      @(negedge clk25);
      case (mode)
        0: pix_en = 1'b1;
        1: pix_en = ~pix_en;
        default: pix_en = 1'($urandom_range(0, 1));
      endcase
      guard++;
    end
    if (n < target) chk("run_until_budget", n, target);
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(negedge clk25);
    run_chk = 1;
    repeat (2) @(negedge clk25);
    reset = 1'b0;
    repeat (2) @(negedge clk25);   // idle with pixEn=0: outputs must hold

    // Continuous ticks up to raster position (6,3), then reset mid-line.
    run_until(48, 200, 0);
    chk("mid_reset_position", n, 48);
    #2 reset = 1'b1;
    #1;
    chk("imm_rst_A_active", int'(ifa.active), 0);
    chk("imm_rst_A_hSync", int'(ifa.hSync), 1);
    chk("imm_rst_A_vSync", int'(ifa.vSync), 1);
    chk("imm_rst_A_x", int'(ifa.x), 0);
    chk("imm_rst_A_y", int'(ifa.y), 0);
    chk("imm_rst_A_lineStart", int'(ifa.lineStart), 0);
    chk("imm_rst_A_fc", int'(ifa.frameCount), 0);
    chk("imm_rst_B_active", int'(ifb.active), 0);
    @(negedge clk25);
    @(negedge clk25);
    reset = 1'b0;                  // pixEn stays 1 across the release

    run_until(120, 400, 0);        // covers the first screenEnd
    run_until(300, 1000, 1);       // alternating pixEn
    run_until(1100, 20000, 2);     // random pixEn, >= 11 frames of A
    @(negedge clk25);
    run_chk = 0;

    // frameCount of A (FC_W=2) after the mid-line reset: 1,2,3,0,...
    // each appearing on the edge right after that frame's screenEnd.
    chk("fc_transition_count_ge4", (fc_val.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < fc_val.size(); i++) begin
      chk("fc_seq_value", fc_val[i], (i + 1) % 4);
      chk("fc_seq_edge", fc_n[i], 98 * (i + 1) + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
